vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares one single-port packed framebuffer RAM between the VGA display fetch and a pixel writer
//  (the constellation plotter). Sits between the 640x480 timing generator (blank_n, vs) and the RAM.
//  - Prefetches display words into a small FIFO and unpacks them into one pixel per active cycle.
//  - Grants all remaining RAM slots to the writer through a valid/ready handshake.
// PARAMETERS
//  PIX_W        4      bits per pixel colour
//  PIX_PER_WORD 4      pixels packed per RAM word; pixel 0 in LSBs
//  H_ACT        640    active pixels per line
//  V_ACT        480    active lines per frame
//  ADDR_W       17     RAM word-address width; must hold H_ACT*V_ACT/PIX_PER_WORD = 76800
//  FIFO_DEPTH   8      prefetch FIFO depth in words; power of 2
//  LOW_WATER    2      below this (level+inflight) the display read has priority over the writer
// PORTS
//  clk        in   1                   pixel clock; rising edge; timing inputs change on falling edge
//  reset      in   1                   reset, asynchronous, active-high
//  blank_n    in   1                   1 = active pixel this cycle
//  vs         in   1                   vertical sync, active-low
//  pix_color  out  PIX_W               display pixel, registered
//  pix_valid  out  1                   blank_n delayed by 1 cycle, aligned to pix_color
//  wr_valid   in   1                   writer request
//  wr_ready   out  1                   combinational grant; transfer = wr_valid & wr_ready
//  wr_x       in   10                  writer column
//  wr_y       in   9                   writer row
//  wr_color   in   PIX_W               writer colour
//  mem_en     out  1                   RAM access strobe, registered
//  mem_we     out  1                   1 = write, 0 = read
//  mem_addr   out  ADDR_W              word address = y*(H_ACT/PIX_PER_WORD) + x/PIX_PER_WORD
//  mem_be     out  PIX_PER_WORD        per-pixel write enable; one-hot bit x%PIX_PER_WORD
//  mem_wdata  out  PIX_W*PIX_PER_WORD  wr_color replicated into every lane
//  mem_rdata  in   PIX_W*PIX_PER_WORD  valid exactly 1 cycle after a read's mem_en
//  underflow  out  1                   sticky; set on pixel demand while the FIFO is empty
// BEHAVIOUR
//  - Reset values: every output 0; state IDLE; FIFO empty; read address, in-flight count and sub-pixel index 0.
//  - Fetch FSM:
//    - IDLE: entered while vs=0. Flushes the FIFO, drops in-flight returns, sets read address 0,
//      clears sub-pixel index. IDLE->FILL when vs rises.
//    - FILL: issues display reads at address+1 per read. FILL->DONE once FRAME_WORDS reads are issued.
//    - DONE: issues no reads. DONE->IDLE when vs=0.
//    - vs=0 in any state forces IDLE.
//  - Arbitration, evaluated each cycle; occ = FIFO level + in-flight reads; first match wins:
//    1. FILL & occ<LOW_WATER: display read; wr_ready=0.
//    2. wr_valid: wr_ready=1; write issued.
//    3. FILL & occ<FIFO_DEPTH: display read.
//    4. Otherwise idle; mem_en=0.
//  - Writer latency: accepted in cycle N -> mem_en/mem_we/addr/be/wdata driven in cycle N+1.
//  - Out-of-range write (wr_x>=H_ACT or wr_y>=V_ACT): accepted (wr_ready=1), no RAM access.
//  - Read data is pushed into the FIFO 1 cycle after mem_en; occ never exceeds FIFO_DEPTH, so no overflow.
//  - Pixel out: blank_n=1 -> pix_color <= lane[sub] of the FIFO head; sub increments and wraps at PIX_PER_WORD.
//    The head is popped when sub wraps. Output latency is 1 cycle.
//  - Empty FIFO on demand: pix_color <= 0, underflow <= 1, sub still advances, no pop.
//    Realignment happens at the next IDLE flush. underflow clears only on reset.
//  - Simultaneous push and pop in one cycle are both honoured; the FIFO level is unchanged.
//  - Reset mid-transfer aborts the transfer; an in-flight RAM read is discarded.
// CONFIGURATION
//  VGA_FB_UFLOW_CNT_EN defined: adds output uflow_cnt[15:0]. It counts underflow events, saturates at
//  0xFFFF, and clears on reset. Undefined: no port, no counter; underflow flag only.
// STRUCTURE
//  - Package vga_fb_pkg: H_ACT, V_ACT, WORDS_PER_LINE=160, FRAME_WORDS=76800, fetch-state enum
//    {IDLE,FILL,DONE}, address-calc function.
//  - Sub-module vga_fb_fifo: sync FIFO (push, pop, level, empty); instantiated once.
// TESTING
//  1. Reset held, then released with vs=0 -> all outputs 0, mem_en=0, state IDLE, wr_ready follows wr_valid.
//  2. vs rises, writer idle -> reads at addr 0..7 back-to-back, mem_en stops at occ=8, refill tracks pops.
//     RAM preloaded with word0=0x3210 -> first active pixels 0,1,2,3 with pix_valid=1.
//  3. Writer streams continuously during active video -> display read wins whenever occ<2.
//     No underflow over a full frame; writer gets >=3 of every 4 active cycles.
//  4. Write x=5, y=2 colour 0xA -> next cycle mem_we=1, addr=321, be=0b0010, wdata=0xAAAA.
//  5. Write x=640, y=0 -> wr_ready=1, no mem_en.
//  6. RAM reads forced stalled (blocked by LOW_WATER=0 config) in active video -> pix_color=0, underflow=1.
//     Sticky across the next frame. With VGA_FB_UFLOW_CNT_EN, uflow_cnt equals the starved-pixel count.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: framebuffer geometry, fetch-state type and pixel-to-word
// address helper shared by the arbiter and its FIFO.
package vga_fb_pkg;

    localparam int H_ACT          = 640;
    localparam int V_ACT          = 480;
    localparam int FB_PPW         = 4;
    localparam int WORDS_PER_LINE = H_ACT / FB_PPW;
    localparam int FRAME_WORDS    = WORDS_PER_LINE * V_ACT;
    localparam int FB_ADDR_W      = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

    function automatic logic [FB_ADDR_W-1:0] fb_addr(
        input logic [9:0] x,
        input logic [8:0] y
    );
        return FB_ADDR_W'(y) * FB_ADDR_W'(WORDS_PER_LINE)
             + FB_ADDR_W'(x / 10'(FB_PPW));
    endfunction

endpackage

// File: rtl/vga_fb_fifo.sv
// vga_fb_fifo: show-ahead synchronous FIFO for prefetched display words.
// Flush empties it in one cycle and wins over a same-cycle push.
module vga_fb_fifo
    import vga_fb_pkg::*;
#(
    parameter  int W     = 16,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q;
    logic [PW-1:0] rp_q;
    logic [LW-1:0] lvl_q;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wp_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else if (flush) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (push) begin
                wp_q <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end
            lvl_q <= lvl_q + LW'(push) - LW'(pop);
        end
    end

    assign rdata = mem_q[rp_q];
    assign level = lvl_q;
    assign empty = (lvl_q == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one packed framebuffer RAM between display prefetch
// and a pixel writer. Optional VGA_FB_UFLOW_CNT_EN adds a starved-pixel counter.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int PIX_W        = 4,
    parameter int PIX_PER_WORD = 4,
    parameter int ADDR_W       = 17,
    parameter int FIFO_DEPTH   = 8,
    parameter int LOW_WATER    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          blank_n,
    input  logic                          vs,
    output logic [PIX_W-1:0]              pix_color,
    output logic                          pix_valid,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [9:0]                    wr_x,
    input  logic [8:0]                    wr_y,
    input  logic [PIX_W-1:0]              wr_color,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [PIX_PER_WORD-1:0]       mem_be,
    output logic [PIX_W*PIX_PER_WORD-1:0] mem_wdata,
    input  logic [PIX_W*PIX_PER_WORD-1:0] mem_rdata,
`ifdef VGA_FB_UFLOW_CNT_EN
    output logic [15:0]                   uflow_cnt,
`endif
    output logic                          underflow
);

    localparam int DW     = PIX_W * PIX_PER_WORD;
    localparam int LANE_W = $clog2(PIX_PER_WORD);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e          state_q;
    logic [ADDR_W-1:0]     raddr_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [PIX_PER_WORD-1:0] mem_be_q;
    logic [DW-1:0]         mem_wdata_q;
    logic                  rd_ret_q;
    logic [LANE_W-1:0]     sub_q;
    logic [PIX_W-1:0]      pix_color_q;
    logic                  pix_valid_q;
    logic                  underflow_q;

    logic                  flush;
    logic                  rd_pend;
    logic [LVL_W-1:0]      level;
    logic [LVL_W-1:0]      occ;
    logic                  empty;
    logic [DW-1:0]         head;
    logic                  fill;
    logic                  low;
    logic                  room;
    logic                  rd_go;
    logic                  wr_go;
    logic                  in_range;
    logic                  sub_last;
    logic                  push;
    logic                  pop;

    // occ counts words already queued plus the two read pipeline stages
    assign flush    = !vs || (state_q == IDLE);
    assign rd_pend  = mem_en_q && !mem_we_q;
    assign occ      = level + LVL_W'(rd_pend) + LVL_W'(rd_ret_q);
    assign fill     = (state_q == FILL) && vs;
    assign low      = fill && (int'(occ) < LOW_WATER);
    assign room     = fill && (int'(occ) < FIFO_DEPTH);
    assign wr_ready = wr_valid && !low;
    assign wr_go    = wr_ready;
    assign rd_go    = low || (!wr_valid && room);
    assign in_range = (wr_x < 10'(H_ACT)) && (wr_y < 9'(V_ACT));
    assign sub_last = (sub_q == LANE_W'(PIX_PER_WORD - 1));
    assign push     = rd_ret_q && !flush;
    assign pop      = blank_n && !empty && !flush && sub_last;

    vga_fb_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (mem_rdata),
        .rdata (head),
        .level (level),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            raddr_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= rd_go || (wr_go && in_range);
            mem_we_q <= wr_go && in_range;
            if (rd_go) begin
                mem_addr_q <= raddr_q;
                mem_be_q   <= '0;
            end else if (wr_go && in_range) begin
                mem_addr_q  <= ADDR_W'(fb_addr(wr_x, wr_y));
                mem_be_q    <= PIX_PER_WORD'(1) << wr_x[LANE_W-1:0];
                mem_wdata_q <= {PIX_PER_WORD{wr_color}};
            end
            if (!vs) begin
                state_q <= IDLE;
                raddr_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= FILL;
                        raddr_q <= '0;
                    end
                    FILL: begin
                        if (rd_go) begin
                            raddr_q <= raddr_q + 1'b1;
                            if (raddr_q == ADDR_W'(FRAME_WORDS - 1)) begin
                                state_q <= DONE;
                            end
                        end
                    end
                    DONE: state_q <= DONE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ret_q    <= 1'b0;
            sub_q       <= '0;
            pix_color_q <= '0;
            pix_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ret_q    <= rd_pend && !flush;
            pix_valid_q <= blank_n;
            if (blank_n) begin
                pix_color_q <= empty ? '0
                             : head[int'(sub_q)*PIX_W +: PIX_W];
                if (empty) begin
                    underflow_q <= 1'b1;
                end
            end else begin
                pix_color_q <= '0;
            end
            // a starved pixel still advances sub so timing stays on grid
            if (flush) begin
                sub_q <= '0;
            end else if (blank_n) begin
                sub_q <= sub_last ? '0 : sub_q + 1'b1;
            end
        end
    end

`ifdef VGA_FB_UFLOW_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ucnt_q <= '0;
        end else if (blank_n && empty && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign uflow_cnt = ucnt_q;
`endif

    assign pix_color = pix_color_q;
    assign pix_valid = pix_valid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for the framebuffer arbiter; a second
// instance with LOW_WATER=0 and a saturating writer starves the display.
module tb_vga_fb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        blank_n, vs, wr_valid, wr_ready;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [3:0]  wr_color, pix_color;
    logic        pix_valid, mem_en, mem_we, underflow;
    logic [16:0] mem_addr;
    logic [3:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    logic        blank2, vs2, wr_ready2;
    logic [3:0]  pix_color2;
    logic        pix_valid2, mem_en2, mem_we2, underflow2;
    logic [16:0] mem_addr2;
    logic [3:0]  mem_be2;
    logic [15:0] mem_wdata2;
`ifdef VGA_FB_UFLOW_CNT_EN
    logic [15:0] uflow_cnt, uflow_cnt2;
`endif

    vga_fb_arbiter u_dut (
        .clk(clk), .reset(reset), .blank_n(blank_n), .vs(vs),
        .pix_color(pix_color), .pix_valid(pix_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef VGA_FB_UFLOW_CNT_EN
        .uflow_cnt(uflow_cnt),
`endif
        .underflow(underflow)
    );

    vga_fb_arbiter #(.LOW_WATER(0)) u_dut2 (
        .clk(clk), .reset(reset), .blank_n(blank2), .vs(vs2),
        .pix_color(pix_color2), .pix_valid(pix_valid2),
        .wr_valid(1'b1), .wr_ready(wr_ready2),
        .wr_x(10'd640), .wr_y(9'd0), .wr_color(4'h0),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_be(mem_be2), .mem_wdata(mem_wdata2), .mem_rdata(16'h0),
`ifdef VGA_FB_UFLOW_CNT_EN
        .uflow_cnt(uflow_cnt2),
`endif
        .underflow(underflow2)
    );

    // RAM word w holds pixels w, w+1, w+2, w+3 (mod 16), lane 0 in LSBs
    function automatic logic [15:0] word_of(input int w);
        logic [3:0] b;
        b = 4'(w);
        return {b + 4'd3, b + 4'd2, b + 4'd1, b};
    endfunction

    function automatic logic [3:0] pix_of(input int p);
        return 4'((p / 4) + (p % 4));
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= word_of(int'(mem_addr));
    end

    typedef struct packed {
        logic [16:0] addr;
        logic [3:0]  be;
        logic [15:0] wdata;
    } wr_t;

    wr_t        wr_q[$];
    logic [3:0] pix_q[$];
    wr_t        e;
    logic [3:0] ep;
    int checks = 0, errors = 0, cyc = 0;
    int rd_exp = 0, rd_first = -1, rd_last = -1, m2_cnt = 0, pix_n = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // monitor: pops expectations whenever the DUT presents an output
    always @(negedge clk) begin
        cyc++;
        if (mem_en2) m2_cnt++;
        if (mem_en === 1'b1) begin
            checks++;
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d", mem_addr);
                end else begin
                    e = wr_q.pop_front();
                    if ({mem_addr, mem_be, mem_wdata} !== e) begin
                        errors++;
                        $display("FAIL mem_write got=%0d/%b/%h exp=%0d/%b/%h",
                                 mem_addr, mem_be, mem_wdata,
                                 e.addr, e.be, e.wdata);
                    end
                end
            end else begin
                if (mem_addr !== 17'(rd_exp)) begin
                    errors++;
                    $display("FAIL read_addr got=%0d exp=%0d",
                             mem_addr, rd_exp);
                end
                if (rd_exp == 0) rd_first = cyc;
                rd_last = cyc;
                rd_exp++;
            end
        end
        if (pix_valid === 1'b1) begin
            checks++;
            if (pix_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel got=%h", pix_color);
            end else begin
                ep = pix_q.pop_front();
                if (pix_color !== ep) begin
                    errors++;
                    $display("FAIL pixel got=%h exp=%h", pix_color, ep);
                end
            end
        end
    end

    task automatic cyc1(input logic bn, input logic v, input logic wv,
                        input logic [9:0] x, input logic [8:0] y,
                        input logic [3:0] c, output logic acc);
        @(negedge clk);
        blank_n = bn; vs = v; wr_valid = wv;
        wr_x = x; wr_y = y; wr_color = c;
        if (bn) begin
            pix_q.push_back(pix_of(pix_n));
            pix_n++;
        end
        #4;
        acc = wv && wr_ready;
        if (acc && x < 10'd640 && y < 9'd480)
            wr_q.push_back({17'(int'(y) * 160 + int'(x) / 4),
                            4'(1 << (int'(x) % 4)), {4{c}}});
    endtask

    task automatic cyc2(input logic bn, input logic v);
        @(negedge clk);
        blank2 = bn; vs2 = v;
    endtask

    initial begin
        logic acc;
        int act, nacc;
        logic [9:0] wx;
        reset = 1'b1; vs = 0; blank_n = 0; wr_valid = 0;
        wr_x = 0; wr_y = 0; wr_color = 0; vs2 = 0; blank2 = 0;
        repeat (3) @(negedge clk);
        chk("rst_pix", {30'd0, pix_valid, 1'b0} | 32'(pix_color), 0);
        chk("rst_mem", {mem_en, mem_we, mem_be}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_flags", {underflow, wr_ready}, 0);
        reset = 1'b0;

        cyc1(0, 0, 1, 10'd640, 9'd0, 4'h0, acc);
        chk("rdy_follow_hi", acc, 1);
        @(posedge clk); #1;
        chk("oob_x_no_mem", mem_en, 0);
        cyc1(0, 0, 0, 10'd0, 9'd0, 4'h0, acc);
        chk("rdy_follow_lo", wr_ready, 0);
        cyc1(0, 0, 1, 10'd3, 9'd480, 4'h1, acc);
        chk("oob_y_ready", acc, 1);
        @(posedge clk); #1;
        chk("oob_y_no_mem", mem_en, 0);
        cyc1(0, 0, 1, 10'd5, 9'd2, 4'hA, acc);
        @(posedge clk); #1;
        chk("w_we", mem_we, 1);
        chk("w_addr", mem_addr, 321);
        chk("w_be", mem_be, 4'b0010);
        chk("w_wdata", mem_wdata, 16'hAAAA);
        cyc1(0, 0, 0, 10'd0, 9'd0, 4'h0, acc);

        repeat (20) cyc1(0, 1, 0, 10'd0, 9'd0, 4'h0, acc);
        chk("prefetch_count", rd_exp, 8);
        chk("prefetch_b2b", rd_last - rd_first, 7);

        wx = 0; act = 0; nacc = 0;
        for (int l = 0; l < 2; l++) begin
            for (int c = 0; c < 800; c++) begin
                cyc1(c < 640, 1, 1, wx, 9'd479, wx[3:0], acc);
                if (c < 640) begin
                    act++;
                    if (acc) nacc++;
                end
                if (acc) wx = (wx == 10'd639) ? 10'd0 : wx + 10'd1;
            end
        end
        chk("writer_share", 32'(nacc * 4 >= act * 3), 1);
        chk("no_uflow_f1", underflow, 0);

        repeat (2) cyc1(0, 0, 0, 10'd0, 9'd0, 4'h0, acc);
        rd_exp = 0; pix_n = 0;
        repeat (3) cyc1(0, 0, 0, 10'd0, 9'd0, 4'h0, acc);
        repeat (12) cyc1(0, 1, 0, 10'd0, 9'd0, 4'h0, acc);
        repeat (640) cyc1(1, 1, 0, 10'd0, 9'd0, 4'h0, acc);
        repeat (8) cyc1(0, 1, 0, 10'd0, 9'd0, 4'h0, acc);
        chk("frame2_reads", rd_exp, 168);
        chk("pix_drained", pix_q.size(), 0);
        chk("wr_drained", wr_q.size(), 0);
        chk("no_uflow_f2", underflow, 0);

        chk("dut2_clean", underflow2, 0);
        repeat (3) cyc2(0, 1);
        cyc2(1, 1);
        @(posedge clk); #1;
        chk("starve_valid", pix_valid2, 1);
        chk("starve_color", pix_color2, 0);
        chk("starve_flag", underflow2, 1);
        repeat (9) cyc2(1, 1);
        repeat (3) cyc2(0, 0);
        repeat (3) cyc2(0, 1);
        chk("uflow_sticky", underflow2, 1);
        chk("dut2_no_reads", m2_cnt, 0);
`ifdef VGA_FB_UFLOW_CNT_EN
        chk("uflow_cnt2", uflow_cnt2, 10);
        chk("uflow_cnt1", uflow_cnt, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
